// File: rtl/mux_rr_arbiter.sv
// Round-robin sequencer in front of a shared 4:1 mux: selects an owner, waits for the
// mux path to settle, then grants. Every outgoing signal comes from a register.
module mux_rr_arbiter #(
    parameter int SETTLE_CYCLES = 2,
    parameter int MAX_HOLD      = 8,
    parameter int CNT_W         = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] req,
    output logic [3:0] grant,
    output logic       addr0,
    output logic       addr1,
    output logic       sel_valid
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        GRANT  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(MAX_HOLD - 1);

    state_t           r_state;
    logic [1:0]       r_addr;
    logic [1:0]       r_last;
    logic [CNT_W-1:0] r_settle_cnt;
    logic [CNT_W-1:0] r_hold_cnt;
    logic [3:0]       r_grant;

    state_t           w_state_nxt;
    logic [1:0]       w_addr_nxt;
    logic [1:0]       w_last_nxt;
    logic [CNT_W-1:0] w_settle_nxt;
    logic [CNT_W-1:0] w_hold_nxt;
    logic [3:0]       w_grant_nxt;
    logic [1:0]       w_winner;
    logic [3:0]       w_owner_oh;
    logic             w_others;
    logic             w_hold_expired;

    // Scan downward so the final overwrite is the nearest requester after 'last'.
    function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] last);
        logic [1:0] idx;
        rr_pick = last;
        for (int k = 4; k >= 1; k--) begin
            idx = last + 2'(k);
            if (r[idx]) rr_pick = idx;
        end
    endfunction

    assign w_winner       = rr_pick(req, r_last);
    assign w_owner_oh     = 4'b0001 << r_addr;
    assign w_others       = |(req & ~w_owner_oh);
    assign w_hold_expired = (MAX_HOLD > 0) && (r_grant != 4'b0000) && (r_hold_cnt == HOLD_LAST);

    // NOTE: every variable gets its default before the case, so no path infers a latch.
    always_comb begin
        w_state_nxt  = r_state;
        w_addr_nxt   = r_addr;
        w_last_nxt   = r_last;
        w_settle_nxt = r_settle_cnt;
        w_hold_nxt   = r_hold_cnt;
        w_grant_nxt  = 4'b0000;
        case (r_state)
            IDLE: begin
                if (req != 4'b0000) begin
                    w_addr_nxt = w_winner;
                    w_last_nxt = w_winner;
                    w_hold_nxt = '0;
                    if (SETTLE_CYCLES > 0) begin
                        w_state_nxt  = SETTLE;
                        w_settle_nxt = SETTLE_LOAD;
                    end else begin
                        w_state_nxt = GRANT;
                    end
                end
            end
            SETTLE: begin
                if (!req[r_addr]) begin
                    w_state_nxt = IDLE;
                end else if (r_settle_cnt == '0) begin
                    w_state_nxt = GRANT;
                end else begin
                    w_settle_nxt = r_settle_cnt - CNT_W'(1);
                end
            end
            GRANT: begin
                // Release wins over preemption; both simply return to IDLE with grant low.
                if (!req[r_addr] || (w_hold_expired && w_others)) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_grant_nxt = w_owner_oh;
                    if (r_grant != 4'b0000 && r_hold_cnt != HOLD_LAST)
                        w_hold_nxt = r_hold_cnt + CNT_W'(1);
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= IDLE;
            r_addr       <= 2'd0;
            r_last       <= 2'd3;
            r_settle_cnt <= '0;
            r_hold_cnt   <= '0;
            r_grant      <= 4'b0000;
        end else begin
            r_state      <= w_state_nxt;
            r_addr       <= w_addr_nxt;
            r_last       <= w_last_nxt;
            r_settle_cnt <= w_settle_nxt;
            r_hold_cnt   <= w_hold_nxt;
            r_grant      <= w_grant_nxt;
        end
    end

    assign grant     = r_grant;
    assign sel_valid = |r_grant;
    assign addr0     = r_addr[0];
    assign addr1     = r_addr[1];

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Bench for mux_rr_arbiter: expected grants are queued as stimulus is applied and
// compared by a monitor whenever the grant bus changes owner.
module tb_mux_rr_arbiter;

    typedef struct {
        logic [3:0] grant;
        int         len;   // 0 = burst length not checked
    } exp_t;

    logic       clk = 1'b0;
    logic       reset_n = 1'b1;
    logic [3:0] req = 4'b0000;
    logic [3:0] grant;
    logic       addr0, addr1, sel_valid;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t exp_q[$];

    mux_rr_arbiter #(.SETTLE_CYCLES(2), .MAX_HOLD(8), .CNT_W(4)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .req      (req),
        .grant    (grant),
        .addr0    (addr0),
        .addr1    (addr1),
        .sel_valid(sel_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [1:0] oh_idx(input logic [3:0] oh);
        oh_idx = 2'd0;
        for (int i = 0; i < 4; i++) if (oh[i]) oh_idx = 2'(i);
    endfunction

    task automatic push(input logic [3:0] g, input int len);
        exp_t e;
        e.grant = g;
        e.len   = len;
        exp_q.push_back(e);
    endtask

    task automatic wait_grant(input string tag, input logic [3:0] exp, input int budget);
        int n = 0;
        while (grant !== exp && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(tag, grant, exp);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        req     = 4'b0000;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    // Monitor: one scoreboard entry per new grant, plus dead-cycle and burst-length checks.
    logic [3:0] prev_grant = 4'b0000;
    int         burst_len = 0;
    int         cur_len   = 0;
    always @(negedge clk) begin
        exp_t e;
        if (grant !== prev_grant) begin
            check("sel_valid", sel_valid, |grant);
            if (prev_grant != 4'b0000) begin
                if (grant != 4'b0000) check("dead_cycle", grant, 4'b0000);
                if (cur_len != 0) check("burst_len", burst_len, cur_len);
            end
            if (grant != 4'b0000) begin
                check("onehot", $countones(grant), 1);
                if (exp_q.size() == 0) begin
                    check("unexpected_grant", grant, 4'b0000);
                    cur_len = 0;
                end else begin
                    e = exp_q.pop_front();
                    check("sb_grant", grant, e.grant);
                    check("sb_addr", {addr1, addr0}, oh_idx(e.grant));
                    cur_len = e.len;
                end
                burst_len = 1;
            end
        end else if (grant != 4'b0000) begin
            burst_len++;
        end
        prev_grant = grant;
    end

    initial begin
        // Asynchronous reset with all requests up, before any clock edge.
        #1;
        reset_n = 1'b0;
        req     = 4'b1111;
        #1;
        check("rst_grant", grant, 4'b0000);
        check("rst_sel_valid", sel_valid, 1'b0);
        check("rst_addr", {addr1, addr0}, 2'b00);
        @(negedge clk);
        @(negedge clk);
        check("rst_hold_grant", grant, 4'b0000);
        req     = 4'b0000;
        reset_n = 1'b1;

        // Settle latency with a lone request on input 2.
        @(negedge clk);
        push(4'b0100, 0);
        req = 4'b0100;
        @(negedge clk);
        check("lat_addr_e0", {addr1, addr0}, 2'b10);
        check("lat_grant_e0", grant, 4'b0000);
        @(negedge clk);
        check("lat_grant_e1", grant, 4'b0000);
        @(negedge clk);
        check("lat_grant_e2", grant, 4'b0000);
        @(negedge clk);
        check("lat_grant_e3", grant, 4'b0100);
        req = 4'b0000;
        repeat (3) @(negedge clk);
        check("lat_release", grant, 4'b0000);
        check("lat_addr_hold", {addr1, addr0}, 2'b10);

        // Rotation with all four requesting, each owner briefly dropping its request.
        do_reset();
        push(4'b0001, 2);
        push(4'b0010, 2);
        push(4'b0100, 2);
        push(4'b1000, 2);
        push(4'b0001, 2);
        req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            logic [3:0] g;
            g = 4'b0001 << (i % 4);
            wait_grant("rot_wait", g, 20);
            @(negedge clk);
            if (i == 4) req = 4'b0000;
            else req = req & ~g;
            @(negedge clk);
            if (i != 4) req = 4'b1111;
        end
        repeat (4) @(negedge clk);

        // Preemption after MAX_HOLD cycles between two continuous requesters.
        do_reset();
        push(4'b0001, 8);
        push(4'b0010, 8);
        push(4'b0001, 0);
        req = 4'b0011;
        wait_grant("pre_first", 4'b0001, 20);
        wait_grant("pre_second", 4'b0010, 30);
        wait_grant("pre_third", 4'b0001, 30);
        req = 4'b0000;
        repeat (3) @(negedge clk);

        // Aborted settle: one-cycle pulse on 1 never granted; held request on 3 wins.
        do_reset();
        push(4'b1000, 0);
        req = 4'b0010;
        @(negedge clk);
        req = 4'b1000;
        check("abort_addr", {addr1, addr0}, 2'b01);
        @(negedge clk);
        check("abort_no_grant", grant, 4'b0000);
        wait_grant("abort_winner", 4'b1000, 20);
        // Sole requester is never preempted.
        repeat (12) @(negedge clk);
        check("no_preempt_alone", grant, 4'b1000);
        req = 4'b0000;
        repeat (3) @(negedge clk);

        // Reset in the middle of a grant.
        do_reset();
        push(4'b0100, 0);
        push(4'b0100, 0);
        req = 4'b0100;
        wait_grant("mid_first", 4'b0100, 20);
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check("mid_rst_grant", grant, 4'b0000);
        check("mid_rst_valid", sel_valid, 1'b0);
        check("mid_rst_addr", {addr1, addr0}, 2'b00);
        @(negedge clk);
        reset_n = 1'b1;
        wait_grant("mid_regrant", 4'b0100, 20);
        req = 4'b0000;
        repeat (3) @(negedge clk);

        check("sb_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
